// File: rtl/spi_burst_decoder.sv
// SPI burst decoder: turns CS-framed command/data bytes into address/word write strobes.
// Optional address range check enabled by defining SPI_DEC_RANGE_CHECK_EN.
module spi_burst_decoder #(
    parameter int ADDR_W     = 5,
    parameter int DATA_BYTES = 2,
    parameter int ADDR_LIMIT = 24
) (
    input  logic                    clk_in,
    input  logic                    reset_n_in,
    input  logic [7:0]              data_in,
    input  logic                    data_valid_in,
    input  logic                    transaction_valid_in,
    output logic [8*DATA_BYTES-1:0] data_out,
    output logic [ADDR_W-1:0]       addr_out,
    output logic                    data_valid_out,
    output logic                    frame_err_out,
    output logic                    busy_out
);

    localparam int W  = 8 * DATA_BYTES;
    localparam int CW = 3;

`ifdef SPI_DEC_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CMD, DATA, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              burst_q, burst_d;
    logic [CW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [7:0]        word_cnt_q, word_cnt_d;
    logic [W-1:0]      shift_q, shift_d;
    logic              range_err_q, range_err_d;
    logic [W-1:0]      data_q, data_d;
    logic [ADDR_W-1:0] addr_out_q, addr_out_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic              accept;
    logic              last_byte;
    logic              range_hit;
    logic [W-1:0]      word;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        burst_d     = burst_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        shift_d     = shift_q;
        range_err_d = range_err_q;
        data_d      = data_q;
        addr_out_d  = addr_out_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;

        accept    = data_valid_in & transaction_valid_in;
        last_byte = (byte_cnt_q == CW'(DATA_BYTES - 1));
        range_hit = RANGE_EN && (int'(addr_q) >= ADDR_LIMIT);
        // Truncation keeps the newest W bits: older bytes move toward the MSB
        word      = W'({shift_q, data_in});

        unique case (state_q)
            IDLE: begin
                if (transaction_valid_in) begin
                    state_d     = CMD;
                    byte_cnt_d  = '0;
                    word_cnt_d  = '0;
                    range_err_d = 1'b0;
                end
            end
            CMD: begin
                if (accept) begin
                    addr_d      = data_in[ADDR_W-1:0];
                    burst_d     = data_in[7];
                    byte_cnt_d  = '0;
                    word_cnt_d  = '0;
                    range_err_d = 1'b0;
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    shift_d = word;
                    if (last_byte) begin
                        byte_cnt_d = '0;
                        if (word_cnt_q != 8'hFF) begin
                            word_cnt_d = word_cnt_q + 8'd1;
                        end
                        if (range_hit) begin
                            range_err_d = 1'b1;
                        end else begin
                            valid_d    = 1'b1;
                            data_d     = word;
                            addr_out_d = addr_q;
                        end
                        if (burst_q) begin
                            addr_d = addr_q + ADDR_W'(1);
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
            end
            default: state_d = IDLE;
        endcase

        // CS release ends the frame from any active state
        if (state_q != IDLE && !transaction_valid_in) begin
            state_d = IDLE;
            err_d   = (state_q == DATA && byte_cnt_q != '0) ||
                      (word_cnt_q == 8'd0) || range_err_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            burst_q     <= 1'b0;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            shift_q     <= '0;
            range_err_q <= 1'b0;
            data_q      <= '0;
            addr_out_q  <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            burst_q     <= burst_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            shift_q     <= shift_d;
            range_err_q <= range_err_d;
            data_q      <= data_d;
            addr_out_q  <= addr_out_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign data_out       = data_q;
    assign addr_out       = addr_out_q;
    assign data_valid_out = valid_q;
    assign frame_err_out  = err_q;
    assign busy_out       = (state_q != IDLE);

endmodule
